// File: rtl/uarch.sv
// Shared microarchitecture types for the core: pointer/word widths, fetch
// buffer depth, and the fetch-to-decode payload.
package uarch;

    localparam int FETCH_DEPTH = 4;

    typedef logic [30:0] hptr;
    typedef logic [31:0] word;

    typedef struct packed {
        word insn;
        hptr pc;
    } insn_fetch;

endpackage

// File: rtl/core_fetch_fifo.sv
// Prefetch buffer between the instruction bus returns and decode: a small
// synchronous FIFO with flush, whose head is read directly from storage.
module core_fetch_fifo
    import uarch::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_flush,
    input  logic            i_push,
    input  logic            i_pop,
    input  insn_fetch       i_data,
    output insn_fetch       o_head,
    output logic            o_valid,
    output logic [CW-1:0]   o_count
);

    insn_fetch       r_mem [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic            w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign o_valid = (r_count != '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(i_push) - CW'(w_pop);
        end
    end

    // NOTE: storage has no reset; entries are only observed once the count
    // says they were written, so resetting them would buy nothing.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

`ifndef SYNTHESIS
    // Push into a full buffer is only legal when the head leaves the same edge.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !i_flush && !w_pop && (r_count == CW'(DEPTH))));
`endif

endmodule

// File: rtl/core_fetch.sv
// Instruction fetch front end: issues pipelined word reads, buffers returns,
// hands one instruction per cycle to decode and drops fetches orphaned by a
// redirect.
module core_fetch
    import uarch::*;
#(
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch,
    input  logic [30:0] target,
    input  logic        stall,
    output logic [31:0] insn_addr,
    output logic        insn_read,
    input  logic        insn_waitrequest,
    input  logic [31:0] insn_readdata,
    input  logic        insn_readdatavalid,
    output logic [31:0] insn,
    output logic [30:0] insn_pc,
    output logic        insn_valid
);

    localparam int            CW  = $clog2(DEPTH + 1);
    localparam logic [CW:0]   CAP = (CW + 1)'(DEPTH);

    hptr           r_fetch_ptr;
    hptr           r_ret_pc;
    logic [CW-1:0] r_pending;
    logic [CW-1:0] r_discard;
    logic          r_started;
    logic          r_held;
    logic          r_held_stale;
    word           r_held_addr;

    hptr           w_target_aligned;
    logic [CW-1:0] w_count;
    logic [CW:0]   w_occupancy;
    logic [CW-1:0] w_pending_nxt;
    logic          w_issue;
    logic          w_accept;
    logic          w_disc_dec;
    logic          w_push;
    logic          w_pop;
    logic          w_fifo_valid;
    insn_fetch     w_head;
    insn_fetch     w_push_data;

    assign w_target_aligned = target & 31'h7FFF_FFFE;

    // Buffered plus in-flight words must fit the buffer, so no return can overflow it.
    assign w_occupancy = {1'b0, w_count} + {1'b0, r_pending};
    assign w_issue     = r_started && !branch && (w_occupancy < CAP);

    assign insn_read  = r_held || w_issue;
    assign insn_addr  = r_held ? r_held_addr : {r_fetch_ptr[30:1], 2'b00};
    assign w_accept   = insn_read && !insn_waitrequest;

    assign w_pending_nxt = r_pending + CW'(w_accept) - CW'(insn_readdatavalid);
    assign w_disc_dec    = insn_readdatavalid && (r_discard != '0);
    assign w_push        = insn_readdatavalid && (r_discard == '0) && !branch;
    assign w_push_data   = '{insn: insn_readdata, pc: r_ret_pc};

    assign insn_valid = w_fifo_valid && !branch;
    assign w_pop      = insn_valid && !stall;
    assign insn       = w_head.insn;
    assign insn_pc    = w_head.pc;

    core_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (branch),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_data),
        .o_head  (w_head),
        .o_valid (w_fifo_valid),
        .o_count (w_count)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // here sees the pre-edge value of every other one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_ptr  <= '0;
            r_ret_pc     <= '0;
            r_pending    <= '0;
            r_discard    <= '0;
            r_started    <= 1'b0;
            r_held       <= 1'b0;
            r_held_stale <= 1'b0;
            r_held_addr  <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_held    <= insn_read && insn_waitrequest;
            if (insn_read && insn_waitrequest) r_held_addr <= insn_addr;

            // A request stuck on the bus across a redirect belongs to the old stream.
            if (w_accept)             r_held_stale <= 1'b0;
            else if (branch && r_held) r_held_stale <= 1'b1;

            if (branch) begin
                r_fetch_ptr <= w_target_aligned;
                r_ret_pc    <= w_target_aligned;
                r_started   <= 1'b1;
                r_discard   <= w_pending_nxt;
            end else begin
                if (w_accept && !r_held_stale) r_fetch_ptr <= r_fetch_ptr + 31'd2;
                if (w_push)                    r_ret_pc    <= r_ret_pc + 31'd2;
                r_discard <= r_discard - CW'(w_disc_dec) + CW'(w_accept && r_held_stale);
            end
        end
    end

endmodule

// File: tb/tb_core_fetch.sv
// Randomized bench for core_fetch: a bus model with variable latency and a
// stream-level reference (after a redirect, decode sees target, target+2, ...).
module tb_core_fetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        branch;
    logic [30:0] target;
    logic        stall;
    logic [31:0] insn_addr;
    logic        insn_read;
    logic        insn_waitrequest;
    logic [31:0] insn_readdata;
    logic        insn_readdatavalid;
    logic [31:0] insn;
    logic [30:0] insn_pc;
    logic        insn_valid;

    core_fetch #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .branch             (branch),
        .target             (target),
        .stall              (stall),
        .insn_addr          (insn_addr),
        .insn_read          (insn_read),
        .insn_waitrequest   (insn_waitrequest),
        .insn_readdata      (insn_readdata),
        .insn_readdatavalid (insn_readdatavalid),
        .insn               (insn),
        .insn_pc            (insn_pc),
        .insn_valid         (insn_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          ready;
    } mreq_t;

    mreq_t       mq[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          n_accept = 0;
    int          n_consumed = 0;

    // reference state
    bit          started_m = 0;
    logic [31:0] exp_fetch = '0;
    logic [30:0] exp_pc = '0;
    bit          prev_held = 0;
    logic [31:0] prev_addr = '0;
    bit          held_stale = 0;

    // stimulus knobs; force_* < 0 means randomize
    int          p_branch = 0, p_stall = 0, p_wait = 0, p_rdv = 100, lat_max = 1;
    int          force_stall = 0, force_wait = 0;
    bit          force_branch = 0;
    logic [30:0] force_tgt = '0;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic cycle();
        bit accept;
        @(negedge clk);
        if (force_branch) begin
            branch = 1'b1;
            target = force_tgt;
            force_branch = 0;
        end else begin
            branch = ($urandom_range(0, 99) < p_branch);
            target = ($urandom_range(0, 49) == 0) ? 31'h7FFF_FFF0 | 31'($urandom_range(0, 15))
                                                  : 31'($urandom_range(0, 511));
        end
        stall            = (force_stall >= 0) ? force_stall[0] : ($urandom_range(0, 99) < p_stall);
        insn_waitrequest = (force_wait >= 0) ? force_wait[0] : ($urandom_range(0, 99) < p_wait);
        if (mq.size() > 0 && mq[0].ready <= cyc && $urandom_range(0, 99) < p_rdv) begin
            insn_readdatavalid = 1'b1;
            insn_readdata      = mem_word(mq[0].addr);
        end else begin
            insn_readdatavalid = 1'b0;
            insn_readdata      = $urandom();
        end
        #1;
        if (!started_m) begin
            check("idle_read", insn_read, 1'b0);
            check("idle_valid", insn_valid, 1'b0);
        end
        if (branch) check("valid_gated", insn_valid, 1'b0);
        if (insn_valid && !stall) begin
            check("insn_pc", insn_pc, exp_pc);
            check("insn_word", insn, mem_word({exp_pc, 1'b0}));
            exp_pc = exp_pc + 31'd2;
            n_consumed++;
        end
        if (insn_read) begin
            if (prev_held) check("held_addr", insn_addr, prev_addr);
            else           check("fetch_addr", insn_addr, exp_fetch);
        end
        accept = insn_read && !insn_waitrequest;

        // effects of the coming edge
        if (insn_readdatavalid) void'(mq.pop_front());
        if (accept) begin
            mq.push_back('{addr: insn_addr, ready: cyc + 1 + $urandom_range(0, lat_max - 1)});
            n_accept++;
            check("read_cap", mq.size() <= DEPTH, 1'b1);
        end
        if (branch) begin
            exp_fetch = {target[30:1], 2'b00};
            exp_pc    = {target[30:1], 1'b0};
            started_m = 1;
        end else if (accept && !held_stale) begin
            exp_fetch = exp_fetch + 32'd4;
        end
        if (accept)                  held_stale = 0;
        else if (branch && insn_read) held_stale = 1;
        prev_held = insn_read && insn_waitrequest;
        prev_addr = insn_addr;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        branch = 1'b0;
        stall = 1'b0;
        insn_waitrequest = 1'b0;
        insn_readdatavalid = 1'b0;
        #1;
        check("rst_read", insn_read, 1'b0);
        check("rst_valid", insn_valid, 1'b0);
        check("rst_addr", insn_addr, 32'h0);
        mq.delete();
        started_m = 0;
        prev_held = 0;
        held_stale = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic directed_knobs(int lat);
        p_branch = 0; p_stall = 0; p_wait = 0; p_rdv = 100; lat_max = lat;
        force_stall = 0; force_wait = 0;
    endtask

    initial begin
        int k, a0, c0;
        rst_n = 1'b0;
        branch = 1'b0; target = '0; stall = 1'b0;
        insn_waitrequest = 1'b0; insn_readdatavalid = 1'b0; insn_readdata = '0;
        #1;
        check("rst_read", insn_read, 1'b0);
        check("rst_valid", insn_valid, 1'b0);
        check("rst_addr", insn_addr, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // reset vector, 1-cycle memory: first instruction three cycles after the redirect
        directed_knobs(1);
        repeat (3) cycle();
        force_branch = 1; force_tgt = '0;
        cycle();
        for (k = 1; k <= 10; k++) begin
            cycle();
            if (insn_valid) break;
        end
        check("first_valid_lat", k, 3);
        c0 = n_consumed;
        repeat (8) cycle();
        check("steady_rate", n_consumed - c0, 8);

        // stall held: buffer plus in-flight reads cap at DEPTH
        do_reset();
        directed_knobs(1);
        force_stall = 1;
        a0 = n_accept;
        force_branch = 1; force_tgt = 31'h10;
        repeat (12) cycle();
        check("stall_accepts", n_accept - a0, DEPTH);
        check("stall_read_off", insn_read, 1'b0);
        force_stall = 0;
        c0 = n_consumed;
        repeat (10) cycle();
        check("stall_release", (n_consumed - c0) >= DEPTH, 1'b1);

        // redirect with reads outstanding
        directed_knobs(4);
        repeat (6) cycle();
        force_branch = 1; force_tgt = 31'h40;
        cycle();
        cycle();
        check("redir_addr", insn_addr, 32'h80);
        repeat (12) cycle();

        // misaligned target
        force_branch = 1; force_tgt = 31'h21;
        cycle();
        cycle();
        check("odd_addr", insn_addr, 32'h40);
        repeat (10) cycle();

        // request held under waitrequest across a redirect
        do_reset();
        directed_knobs(1);
        force_wait = 1;
        force_branch = 1; force_tgt = 31'h8;
        cycle();
        cycle();
        check("wait_addr", insn_addr, 32'h10);
        force_branch = 1; force_tgt = 31'h100;
        cycle();
        cycle();
        force_wait = 0;
        cycle();
        cycle();
        check("after_stale_read", insn_read, 1'b1);
        check("after_stale_addr", insn_addr, 32'h200);
        repeat (10) cycle();

        // reset with reads in flight
        directed_knobs(4);
        repeat (5) cycle();
        do_reset();
        repeat (4) cycle();

        // randomized traffic with periodic resets
        p_branch = 4; p_stall = 30; p_wait = 25; p_rdv = 80; lat_max = 3;
        force_stall = -1; force_wait = -1;
        for (int r = 0; r < 3; r++) begin
            repeat (900) cycle();
            do_reset();
        end
        check("liveness", n_consumed > 500, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/core_fetch.md
# core_fetch

Instruction fetch front end: the consumer of the `branch`/`target` redirect produced by the execute-stage branch unit. It issues pipelined word reads to instruction memory and buffers returned instructions in a small prefetch FIFO. It presents one instruction plus its halfword PC per cycle to decode under a stall handshake, and discards in-flight fetches after a redirect. The block sits between the instruction bus master port and `core_decode`.

## Interface
- `DEPTH`, 4: prefetch FIFO entries and cap on (buffered + outstanding) reads; power of two, ≥2.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `branch`  in  1  redirect request from branch unit; asserted out of reset with `target`=0 as the reset vector.
- `target`  in  hptr (31)  halfword redirect address; valid when `branch`=1.
- `stall`  in  1  decode cannot accept this cycle.
- `insn_addr`  out  32  byte address of read, `{fetch_ptr[30:1], 2'b00}`.
- `insn_read`  out  1  read request.
- `insn_waitrequest`  in  1  memory not accepting; request must be held unchanged.
- `insn_readdata`  in  32  returned instruction word.
- `insn_readdatavalid`  in  1  return beat, in-order, one per accepted read.
- `insn`  out  32  instruction to decode.
- `insn_pc`  out  hptr  halfword PC of `insn`, bit 0 always 0.
- `insn_valid`  out  1  `insn`/`insn_pc` valid; consumed when `insn_valid && !stall`.

## Operation
- Reset values: `insn_read`=0, `insn_valid`=0, `insn_addr`=0, FIFO empty, `pending`=0, `discard`=0, `started`=0. No reads until the first `branch`.
- State: `fetch_ptr` (hptr), `pending` (outstanding accepted reads, `$clog2(DEPTH+1)` bits), `discard` (returns to drop), FIFO `count`.
- Redirect (`branch`=1 at an edge): `fetch_ptr`←`{target[30:1],1'b0}` (misaligned target forced to word alignment); FIFO cleared; `discard`←`pending` + (read accepted this cycle); `started`←1. `insn_valid` is gated by `!branch` combinationally.
- Issue: `insn_read`=1 when `started && !branch && count+pending < DEPTH`, or when a request is already held under `insn_waitrequest`. A held request keeps `insn_addr`/`insn_read` stable until accepted, even across a redirect. In that case it is counted into `discard` upon acceptance.
- Accept (`insn_read && !insn_waitrequest`): `pending`+1; `fetch_ptr`+2 (next word), unless a redirect occurs the same edge.
- Return (`insn_readdatavalid`): `pending`−1. If `discard`>0, then `discard`−1 and the word is dropped. Otherwise the word is pushed with its PC. The PC comes from a parallel return-PC counter loaded on redirect and incremented by 2 per non-discarded push.
- Pop: `insn_valid && !stall` advances the FIFO head.
- Simultaneous push+pop while full: legal, `count` unchanged. Push while full without a pop cannot occur by the issue cap; flagged by assertion.
- `fetch_ptr` wraps modulo 2^31.

## Timing
- Redirect at edge N → `insn_read`=1, `insn_addr`=target at N+1. With 1-cycle memory, data returns at N+2 and `insn_valid`=1 at N+3.
- Steady state with no stall and no waitrequest: one read issued and one instruction delivered per cycle.
- FIFO output is registered; `insn_valid` never depends combinationally on `insn_readdatavalid`.
- `stall` affects issue only through `count`, one cycle later.
- Reset mid-operation: all state clears asynchronously. Late memory returns after reset are undefined and excluded by the system.

## Structure
- `hptr`, `word` and `FETCH_DEPTH` live in `uarch.sv`. Add an `insn_fetch` struct `{word insn; hptr pc;}` there for the FIFO entry.
- Sub-module `core_fetch_fifo`: synchronous FIFO with `DEPTH` entries of `insn_fetch`, with flush, push, pop, `count`, head outputs.
- Top-level `core_fetch` holds `fetch_ptr`, the return-PC counter, `pending`/`discard` counters and issue logic.

## Test plan
- Reset then `branch`=1, `target`=0 for one cycle, 1-cycle memory, `stall`=0 → addresses 0x0, 0x4, 0x8…; `insn_pc` 0, 2, 4 from cycle 3.
- `stall`=1 held → at most 4 reads accepted, then `insn_read`=0. Release → insns delivered in order with no gaps or duplicates.
- Redirect to `target`=0x40 with 2 reads pending → both returns dropped; first `insn_pc`=0x40, `insn_addr`=0x80.
- `insn_waitrequest`=1 on a read to 0x10 while `branch` (target 0x100) pulses → 0x10 held until accepted and dropped; next read 0x200.
- Redirect with odd target 0x21 → `insn_addr`=0x40, `insn_pc`=0x20.
- Assert `rst_n`=0 with 3 pending reads → outputs return to reset values immediately; no read until the next `branch`.
